pipe_dest_tracker: RTL

Producer side of the operand-forwarding path. Carries each instruction's destination register, register-write enable and memory-read flag from ID through the ID/EX, EX/MEM and MEM/WB stages. It presents the EX/MEM and MEM/WB destination/write-enable pairs that the forwarding unit compares against EX-stage sources. It also detects load-use hazards, inserts the bubble, drives the PC/IF-ID stall, and keeps a saturating stall counter.

---
 rtl/pipe_dest_tracker.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_dest_tracker.sv
// Destination/write-enable tracker across ID/EX, EX/MEM and MEM/WB.
// Detects load-use hazards, inserts bubbles and counts stalls.
//
// Ports:
//   clk_i, rst_i              clock, async active-low reset
//   id_*                      ID-stage instruction fields
//   flush_i                   kill the ID slot this cycle
//   stall_o                   hold PC and IF/ID
//   ex_*/em_*/mw_*            per-stage rd/regw (ex also memread)
//   stall_cnt_o               saturating load-use bubble count
module pipe_dest_tracker #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regw_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic              ex_regw_o,
  output logic              ex_memread_o,
  output logic [REG_AW-1:0] em_rd_o,
  output logic              em_regw_o,
  output logic [REG_AW-1:0] mw_rd_o,
  output logic              mw_regw_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regw;
    logic              memread;
  } dst_t;

  localparam dst_t BUBBLE = '{rd: '0, regw: 1'b0, memread: 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dst_t ex_q, em_q, mw_q;
  dst_t ex_d;
  logic haz;
  logic src1_hit, src2_hit;

  assign src1_hit = id_use_rs1_i && (id_rs1_i == ex_q.rd);
  assign src2_hit = id_use_rs2_i && (id_rs2_i == ex_q.rd);

  assign haz = id_valid_i && ex_q.memread && (ex_q.rd != '0)
            && (src1_hit || src2_hit);

  // a flushed instruction never needs to wait for its operand
  assign stall_o = haz && !flush_i;

  always_comb begin
    ex_d = BUBBLE;
    if (id_valid_i && !flush_i && !stall_o) begin
      ex_d.rd      = id_rd_i;
      // x0 is never a real write target
      ex_d.regw    = id_regw_i && (id_rd_i != '0);
      ex_d.memread = id_memread_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q <= BUBBLE;
      em_q <= BUBBLE;
      mw_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
      em_q <= ex_q;
      mw_q <= em_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != CNT_MAX)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

  assign ex_rd_o      = ex_q.rd;
  assign ex_regw_o    = ex_q.regw;
  assign ex_memread_o = ex_q.memread;
  assign em_rd_o      = em_q.rd;
  assign em_regw_o    = em_q.regw;
  assign mw_rd_o      = mw_q.rd;
  assign mw_regw_o    = mw_q.regw;

endmodule
